// File: rtl/race_controller.sv
// Frame-rate game sequencer for the track scroller: decodes start/pause/throttle
// keys, runs the idle/countdown/race/crash/over phases and drives the HUD values.
module race_controller #(
   parameter int unsigned FRAMES_PER_SEC = 60,
   parameter int unsigned COUNTDOWN_SECS = 3,
   parameter int unsigned RACE_SECS      = 90,
   parameter int unsigned CRASH_FRAMES   = 120,
   parameter int unsigned ACCEL_PERIOD   = 8,
   parameter int unsigned LIVES          = 3,
   parameter int unsigned START_SPEED    = 5,
   parameter int unsigned MIN_SPEED      = 1,
   parameter int unsigned MAX_SPEED      = 7
) (
   input  logic        frame_clk_i,
   input  logic        reset_i,
   input  logic [7:0]  keycode_i,
   input  logic        collision_i,
   output logic [2:0]  speed_o,
   output logic        scroll_en_o,
   output logic [2:0]  state_o,
   output logic [1:0]  countdown_o,
   output logic [6:0]  time_left_o,
   output logic [15:0] score_o,
   output logic [1:0]  lives_o,
   output logic        game_over_o
);

   // state     | meaning
   // S_IDLE    | waiting for an R edge, track stopped
   // S_COUNT   | pre-race countdown, one step per game second
   // S_RACE    | track scrolling, score and race time running
   // S_PAUSE   | everything frozen until the next P edge
   // S_CRASH   | freeze after a collision, race time still running
   // S_OVER    | final score shown until an R edge
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_COUNT = 3'd1,
      S_RACE  = 3'd2,
      S_PAUSE = 3'd3,
      S_CRASH = 3'd4,
      S_OVER  = 3'd5
   } state_t;

   localparam logic [7:0] KEY_R = 8'h15;
   localparam logic [7:0] KEY_W = 8'h1A;
   localparam logic [7:0] KEY_S = 8'h16;
   localparam logic [7:0] KEY_P = 8'h13;

   localparam int unsigned FC_W  = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
   localparam int unsigned CR_W  = (CRASH_FRAMES > 1) ? $clog2(CRASH_FRAMES) : 1;
   localparam int unsigned REP_W = (ACCEL_PERIOD > 1) ? $clog2(ACCEL_PERIOD) : 1;

   localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(FRAMES_PER_SEC - 1);
   localparam logic [CR_W-1:0]  CRASH_LOAD = CR_W'(CRASH_FRAMES - 1);
   localparam logic [REP_W-1:0] REP_LOAD   = REP_W'(ACCEL_PERIOD - 1);
   localparam logic [1:0]       CD_LOAD    = 2'(COUNTDOWN_SECS);
   localparam logic [6:0]       TIME_LOAD  = 7'(RACE_SECS);
   localparam logic [1:0]       LIVES_LOAD = 2'(LIVES);
   localparam logic [2:0]       SPD_START  = 3'(START_SPEED);
   localparam logic [2:0]       SPD_MIN    = 3'(MIN_SPEED);
   localparam logic [2:0]       SPD_MAX    = 3'(MAX_SPEED);

   state_t            state_q, state_d;
   logic [7:0]        prev_key_q;
   logic [FC_W-1:0]   frame_cnt_q, frame_cnt_d;
   logic [CR_W-1:0]   crash_cnt_q, crash_cnt_d;
   logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d;
   logic [2:0]        speed_q, speed_d;
   logic              scroll_en_q, scroll_en_d;
   logic [1:0]        countdown_q, countdown_d;
   logic [6:0]        time_left_q, time_left_d;
   logic [15:0]       score_q, score_d;
   logic [1:0]        lives_q, lives_d;
   logic              game_over_q, game_over_d;

   logic        key_chg;
   logic        edge_r, edge_p, edge_w, edge_s;
   logic        hold_w, hold_s;
   logic        sec_tick;
   logic        entering;
   logic        counting;
   logic [16:0] score_sum;
   logic [2:0]  speed_up, speed_dn;

   assign key_chg  = (keycode_i != prev_key_q);
   assign edge_r   = key_chg && (keycode_i == KEY_R);
   assign edge_p   = key_chg && (keycode_i == KEY_P);
   assign edge_w   = key_chg && (keycode_i == KEY_W);
   assign edge_s   = key_chg && (keycode_i == KEY_S);
   assign hold_w   = (keycode_i == KEY_W);
   assign hold_s   = (keycode_i == KEY_S);
   assign sec_tick = (frame_cnt_q == FC_LAST);
   assign entering = (state_d != state_q);
   assign counting = (state_q == S_COUNT) || (state_q == S_RACE) || (state_q == S_CRASH);

   assign score_sum = {1'b0, score_q} + {14'd0, speed_q};
   assign speed_up  = (speed_q < SPD_MAX) ? speed_q + 3'd1 : speed_q;
   assign speed_dn  = (speed_q > SPD_MIN) ? speed_q - 3'd1 : speed_q;

   always_ff @(posedge frame_clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (edge_r) state_d = S_COUNT;
         end
         S_COUNT: begin
            if (sec_tick && (countdown_q == 2'd1)) state_d = S_RACE;
         end
         S_RACE: begin
            if (sec_tick && (time_left_q == 7'd1)) state_d = S_OVER;
            else if (collision_i)                  state_d = S_CRASH;
            else if (edge_p)                       state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (edge_p) state_d = S_RACE;
         end
         S_CRASH: begin
            if (sec_tick && (time_left_q == 7'd1)) state_d = S_OVER;
            else if (crash_cnt_q == '0)            state_d = (lives_q == 2'd0) ? S_OVER : S_RACE;
         end
         S_OVER: begin
            if (edge_r) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      frame_cnt_d = frame_cnt_q;
      crash_cnt_d = crash_cnt_q;
      rep_cnt_d   = rep_cnt_q;
      speed_d     = speed_q;
      countdown_d = countdown_q;
      time_left_d = time_left_q;
      score_d     = score_q;
      lives_d     = lives_q;
      scroll_en_d = (state_d == S_RACE);
      game_over_d = (state_d == S_OVER);

      // Pause entry and exit keep the frame phase so the second boundary is not shifted.
      if (entering && (state_d != S_PAUSE) && (state_q != S_PAUSE)) begin
         frame_cnt_d = '0;
      end else if (counting) begin
         frame_cnt_d = sec_tick ? '0 : frame_cnt_q + 1'b1;
      end

      if ((state_d == S_CRASH) && (state_q != S_CRASH)) begin
         crash_cnt_d = CRASH_LOAD;
      end else if ((state_q == S_CRASH) && (crash_cnt_q != '0)) begin
         crash_cnt_d = crash_cnt_q - 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (edge_r) begin
               countdown_d = CD_LOAD;
               time_left_d = TIME_LOAD;
               score_d     = '0;
               lives_d     = LIVES_LOAD;
            end
         end
         S_COUNT: begin
            if (sec_tick) countdown_d = countdown_q - 2'd1;
         end
         S_RACE: begin
            score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
            if (sec_tick) time_left_d = time_left_q - 7'd1;
            if ((state_d == S_CRASH) && (lives_q != 2'd0)) lives_d = lives_q - 2'd1;
         end
         S_CRASH: begin
            if (sec_tick) time_left_d = time_left_q - 7'd1;
         end
         default: ;
      endcase

      if (state_q == S_PAUSE) begin
         rep_cnt_d = rep_cnt_q;
      end else if ((state_q != S_RACE) || key_chg || !(hold_w || hold_s)) begin
         rep_cnt_d = REP_LOAD;
      end else begin
         rep_cnt_d = (rep_cnt_q == '0) ? REP_LOAD : rep_cnt_q - 1'b1;
      end

      if (state_d == S_RACE) begin
         if (state_q == S_RACE) begin
            if (edge_w)                                   speed_d = speed_up;
            else if (edge_s)                              speed_d = speed_dn;
            else if (!key_chg && hold_w && rep_cnt_q == '0) speed_d = speed_up;
            else if (!key_chg && hold_s && rep_cnt_q == '0) speed_d = speed_dn;
         end else if (state_q != S_PAUSE) begin
            speed_d = SPD_START;
         end
      end else if (state_d != S_PAUSE) begin
         speed_d = 3'd0;
      end
   end

   always_ff @(posedge frame_clk_i or posedge reset_i) begin
      if (reset_i) begin
         prev_key_q  <= 8'h00;
         frame_cnt_q <= '0;
         crash_cnt_q <= '0;
         rep_cnt_q   <= '0;
         speed_q     <= 3'd0;
         scroll_en_q <= 1'b0;
         countdown_q <= 2'd0;
         time_left_q <= 7'd0;
         score_q     <= 16'd0;
         lives_q     <= 2'd0;
         game_over_q <= 1'b0;
      end else begin
         prev_key_q  <= keycode_i;
         frame_cnt_q <= frame_cnt_d;
         crash_cnt_q <= crash_cnt_d;
         rep_cnt_q   <= rep_cnt_d;
         speed_q     <= speed_d;
         scroll_en_q <= scroll_en_d;
         countdown_q <= countdown_d;
         time_left_q <= time_left_d;
         score_q     <= score_d;
         lives_q     <= lives_d;
         game_over_q <= game_over_d;
      end
   end

   assign state_o     = state_q;
   assign speed_o     = speed_q;
   assign scroll_en_o = scroll_en_q;
   assign countdown_o = countdown_q;
   assign time_left_o = time_left_q;
   assign score_o     = score_q;
   assign lives_o     = lives_q;
   assign game_over_o = game_over_q;

endmodule
